// File: rtl/comparator_seq.sv
// Digit-serial magnitude comparator, MSB-first, with valid/ready on both sides
// and three saturating result counters (gt/eq/lt).
// WIDTH must be a multiple of DIGIT.

// One saturating result counter; clear beats increment.
module comparator_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count up on inc, hold at all-ones, zero on reset or clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module comparator_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2:0]       o_f,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_gt,
  output logic [CNT_W-1:0] o_cnt_eq,
  output logic [CNT_W-1:0] o_cnt_lt
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             sgn;
  logic [IDX_W-1:0] idx;
  logic [2:0]       f;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             last;
  logic             hs;

  // Ready/valid are pure state decodes; result is a register.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_f     = f;

  assign last = (idx == IDX_W'(NDIG - 1));
  assign hs   = (state == DONE) && i_ready;

  // Current top digit; in signed mode the sign bit is flipped on digit 0 so
  // two's-complement order matches unsigned order (offset binary).
  always_comb begin
    dig_a = a_sh[WIDTH-1 -: DIGIT];
    dig_b = b_sh[WIDTH-1 -: DIGIT];
    if (sgn && (idx == '0)) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
  end

  // Control FSM: capture in IDLE, walk digits in RUN, hold result in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sgn   <= 1'b0;
      idx   <= '0;
      f     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh  <= i_a;
            b_sh  <= i_b;
            sgn   <= i_signed;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (dig_a > dig_b) begin
            f     <= F_GT;
            state <= DONE;
          end else if (dig_a < dig_b) begin
            f     <= F_LT;
            state <= DONE;
          end else if (last) begin
            f     <= F_EQ;
            state <= DONE;
          end else begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
            idx  <= idx + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            f     <= 3'b000;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          f     <= 3'b000;
        end
      endcase
    end
  end

  // Counter bank indexed by result bit: [2]=gt, [1]=eq, [0]=lt.
  logic [2:0][CNT_W-1:0] cnt;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    comparator_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (i_clk),
      .rst (i_rst),
      .clr (i_clr_cnt),
      .inc (hs && f[g]),
      .cnt (cnt[g])
    );
  end

  assign o_cnt_gt = cnt[2];
  assign o_cnt_eq = cnt[1];
  assign o_cnt_lt = cnt[0];

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq: directed scenarios plus randomized ops checked
// against a behavioural model. Two DUTs share stimulus; the second has 2-bit
// counters to exercise saturation.
module tb_comparator_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_a = '0, i_b = '0;
  logic       i_signed = 1'b0;
  logic       i_ready = 1'b0;
  logic       i_clr_cnt = 1'b0;

  logic        o_ready, o_valid;
  logic [2:0]  o_f;
  logic [15:0] cg, ce, cl;
  logic        r2, v2;
  logic [2:0]  f2;
  logic [1:0]  sg, se, sl;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int mg = 0, me = 0, ml = 0;

  always #5 i_clk = ~i_clk;

  comparator_seq #(.WIDTH(8), .DIGIT(2), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .o_valid(o_valid),
    .i_ready(i_ready), .o_f(o_f), .i_clr_cnt(i_clr_cnt),
    .o_cnt_gt(cg), .o_cnt_eq(ce), .o_cnt_lt(cl)
  );

  comparator_seq #(.WIDTH(8), .DIGIT(2), .CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(r2),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .o_valid(v2),
    .i_ready(i_ready), .o_f(f2), .i_clr_cnt(i_clr_cnt),
    .o_cnt_gt(sg), .o_cnt_eq(se), .o_cnt_lt(sl)
  );

  // ---------------- reference model ----------------
  function automatic logic [2:0] exp_f(input logic [7:0] a, input logic [7:0] b, input logic s);
    int va, vb;
    va = s ? int'($signed(a)) : int'(a);
    vb = s ? int'($signed(b)) : int'(b);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    return 3'b010;
  endfunction

  // Latency = 1-based index of first differing 2-bit digit from the MSB, else 4.
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    for (int d = 0; d < 4; d++)
      if (x[7-2*d -: 2] != 2'b00) return d + 1;
    return 4;
  endfunction

  function automatic logic [47:0] cnt16();
    return {16'(mg > 65535 ? 65535 : mg), 16'(me > 65535 ? 65535 : me), 16'(ml > 65535 ? 65535 : ml)};
  endfunction

  function automatic logic [5:0] cnt2();
    return {2'(mg > 3 ? 3 : mg), 2'(me > 3 ? 3 : me), 2'(ml > 3 ? 3 : ml)};
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge i_clk); #1;
  endtask

  // Present operands, wait for the result; scrambles inputs while busy.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output logic [2:0] f, output logic rdy_ok);
    i_a = a; i_b = b; i_signed = s; i_valid = 1'b1;
    rdy_ok = (o_ready === 1'b1);
    step();
    lat = 0;
    while (o_valid !== 1'b1 && lat < 20) begin
      if (o_ready !== 1'b0) rdy_ok = 1'b0;
      i_valid = 1'($urandom); i_a = 8'($urandom); i_b = 8'($urandom); i_signed = 1'($urandom);
      step();
      lat++;
    end
    i_valid = 1'b0;
    if (o_ready !== 1'b0) rdy_ok = 1'b0;
    if (lat >= 20) begin
      tot_cnt++;
      $display("FAIL issue_timeout a=%h b=%h: no o_valid within 20 cycles", a, b);
    end
    f = o_f;
  endtask

  // Output handshake; updates model counters from the expected result.
  task automatic handshake(input logic [2:0] ef, input logic clr);
    i_ready = 1'b1; i_clr_cnt = clr; i_valid = 1'b0;
    step();
    i_ready = 1'b0; i_clr_cnt = 1'b0;
    if (clr) begin
      mg = 0; me = 0; ml = 0;
    end else begin
      if (ef == 3'b100) mg++;
      if (ef == 3'b010) me++;
      if (ef == 3'b001) ml++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    mg = 0; me = 0; ml = 0;
    tot_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", o_ready); else pass_cnt++;
    tot_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else pass_cnt++;
    tot_cnt++; if (o_f !== 3'b000) $display("FAIL reset_f got=%b exp=000", o_f); else pass_cnt++;
    tot_cnt++; if ({cg, ce, cl} !== 48'd0) $display("FAIL reset_cnt got=%h exp=0", {cg, ce, cl}); else pass_cnt++;
    tot_cnt++; if ({sg, se, sl} !== 6'd0) $display("FAIL reset_cnt2 got=%h exp=0", {sg, se, sl}); else pass_cnt++;
  endtask

  task automatic test_equal();
    int lat; logic [2:0] f; logic rok;
    issue(8'h5A, 8'h5A, 1'b0, lat, f, rok);
    tot_cnt++; if (lat != 4) $display("FAIL eq_latency got=%0d exp=4", lat); else pass_cnt++;
    tot_cnt++; if (f !== 3'b010) $display("FAIL eq_f got=%b exp=010", f); else pass_cnt++;
    tot_cnt++; if (rok !== 1'b1) $display("FAIL eq_ready_low got=%b exp=1", rok); else pass_cnt++;
    handshake(3'b010, 1'b0);
    tot_cnt++; if (ce !== 16'd1) $display("FAIL eq_cnt got=%0d exp=1", ce); else pass_cnt++;
    tot_cnt++; if ({o_ready, o_valid, o_f} !== 5'b10000) $display("FAIL eq_post got=%b exp=10000", {o_ready, o_valid, o_f}); else pass_cnt++;
  endtask

  task automatic test_signed_modes();
    logic [7:0] ta [3] = '{8'h80, 8'h80, 8'hFF};
    logic [7:0] tb [3] = '{8'h7F, 8'h7F, 8'h01};
    logic       ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0] tf [3] = '{3'b100, 3'b001, 3'b001};
    int lat; logic [2:0] f; logic rok;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], ts[i], lat, f, rok);
      tot_cnt++; if (lat != 1) $display("FAIL sign_latency[%0d] got=%0d exp=1", i, lat); else pass_cnt++;
      tot_cnt++; if (f !== tf[i]) $display("FAIL sign_f[%0d] got=%b exp=%b", i, f, tf[i]); else pass_cnt++;
      handshake(tf[i], 1'b0);
    end
  endtask

  task automatic test_late_diff();
    int lat; logic [2:0] f; logic rok; int lt0;
    lt0 = ml;
    issue(8'h1C, 8'h1D, 1'b0, lat, f, rok);
    tot_cnt++; if (lat != 4) $display("FAIL late_latency got=%0d exp=4", lat); else pass_cnt++;
    tot_cnt++; if (f !== 3'b001) $display("FAIL late_f got=%b exp=001", f); else pass_cnt++;
    handshake(3'b001, 1'b0);
    tot_cnt++; if (cl !== 16'(lt0 + 1)) $display("FAIL late_cnt_lt got=%0d exp=%0d", cl, lt0 + 1); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] f, ef; logic rok; logic [7:0] a, b; logic s;
    a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
    ef = exp_f(a, b, s);
    issue(a, b, s, lat, f, rok);
    tot_cnt++; if (f !== ef) $display("FAIL bp_f got=%b exp=%b", f, ef); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'($urandom); i_a = 8'($urandom); i_b = 8'($urandom); i_signed = 1'($urandom);
      step();
      tot_cnt++;
      if ({o_valid, o_ready, o_f} !== {1'b1, 1'b0, ef} || {cg, ce, cl} !== cnt16())
        $display("FAIL bp_hold[%0d] got v=%b r=%b f=%b cnt=%h exp v=1 r=0 f=%b cnt=%h",
                 i, o_valid, o_ready, o_f, {cg, ce, cl}, ef, cnt16());
      else pass_cnt++;
    end
    handshake(ef, 1'b0);
    tot_cnt++; if ({cg, ce, cl} !== cnt16()) $display("FAIL bp_cnt got=%h exp=%h", {cg, ce, cl}, cnt16()); else pass_cnt++;
    tot_cnt++; if (o_ready !== 1'b1) $display("FAIL bp_ready got=%b exp=1", o_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [2:0] f; logic rok;
    i_a = 8'h3C; i_b = 8'h3C; i_signed = 1'b0; i_valid = 1'b1;
    step();                       // accept edge
    i_valid = 1'b0;
    step();                       // now in the second RUN cycle
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    mg = 0; me = 0; ml = 0;
    tot_cnt++; if ({o_ready, o_valid, o_f} !== 5'b10000) $display("FAIL rstmid_state got=%b exp=10000", {o_ready, o_valid, o_f}); else pass_cnt++;
    tot_cnt++; if ({cg, ce, cl} !== 48'd0) $display("FAIL rstmid_cnt got=%h exp=0", {cg, ce, cl}); else pass_cnt++;
    issue(8'h03, 8'h02, 1'b0, lat, f, rok);
    tot_cnt++; if (f !== 3'b100 || lat != 4) $display("FAIL rstmid_op got f=%b lat=%0d exp f=100 lat=4", f, lat); else pass_cnt++;
    handshake(3'b100, 1'b0);
    tot_cnt++; if (cg !== 16'd1) $display("FAIL rstmid_cnt_gt got=%0d exp=1", cg); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, el; logic [2:0] f, ef; logic rok; logic [7:0] a, b; logic s;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      if (n % 5 == 0) b = a;
      if (n % 7 == 0) b = a ^ 8'(1 << $urandom_range(7, 0));
      ef = exp_f(a, b, s); el = exp_lat(a, b);
      issue(a, b, s, lat, f, rok);
      tot_cnt++;
      if (f !== ef || lat != el || rok !== 1'b1)
        $display("FAIL rand_op[%0d] a=%h b=%h s=%b got f=%b lat=%0d rdy=%b exp f=%b lat=%0d rdy=1",
                 n, a, b, s, f, lat, rok, ef, el);
      else pass_cnt++;
      repeat ($urandom_range(2, 0)) step();
      handshake(ef, 1'b0);
      tot_cnt++;
      if ({cg, ce, cl} !== cnt16() || {sg, se, sl} !== cnt2())
        $display("FAIL rand_cnt[%0d] got=%h/%h exp=%h/%h", n, {cg, ce, cl}, {sg, se, sl}, cnt16(), cnt2());
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int lat; logic [2:0] f; logic rok; logic [7:0] a;
    i_clr_cnt = 1'b1;
    step();
    i_clr_cnt = 1'b0;
    mg = 0; me = 0; ml = 0;
    tot_cnt++; if ({cg, ce, cl, sg, se, sl} !== 54'd0) $display("FAIL clr_idle got=%h exp=0", {cg, ce, cl, sg, se, sl}); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      issue(a, a, 1'($urandom), lat, f, rok);
      handshake(3'b010, 1'b0);
    end
    tot_cnt++; if (se !== 2'd3) $display("FAIL sat_eq2 got=%0d exp=3", se); else pass_cnt++;
    tot_cnt++; if (ce !== 16'd5) $display("FAIL sat_eq16 got=%0d exp=5", ce); else pass_cnt++;
    issue(8'h77, 8'h77, 1'b0, lat, f, rok);
    handshake(3'b010, 1'b1);
    tot_cnt++; if ({se, ce} !== 18'd0) $display("FAIL clr_wins got se=%0d ce=%0d exp 0/0", se, ce); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_modes();
    test_late_diff();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
